// File: rtl/dmi_jtag_dr.sv
// JTAG data-register back end for the DMI TAP: DTMCS/DMI shift registers and
// conversion of completed DMI scans into a valid/ready request/response exchange.
module dmi_jtag_dr #(
   parameter int unsigned AddrWidth  = 7,
   parameter int unsigned IdleCycles = 1
) (
   input  logic                 tck_i,
   input  logic                 trst_ni,
   input  logic                 dmi_clear_i,
   input  logic                 capture_i,
   input  logic                 shift_i,
   input  logic                 update_i,
   input  logic                 tdi_i,
   input  logic                 dtmcs_select_i,
   output logic                 dtmcs_tdo_o,
   input  logic                 dmi_select_i,
   output logic                 dmi_tdo_o,
   output logic                 dmi_rst_no,
   output logic                 dmi_req_valid_o,
   input  logic                 dmi_req_ready_i,
   output logic [AddrWidth-1:0] dmi_req_addr_o,
   output logic [1:0]           dmi_req_op_o,
   output logic [31:0]          dmi_req_data_o,
   input  logic                 dmi_resp_valid_i,
   output logic                 dmi_resp_ready_o,
   input  logic [31:0]          dmi_resp_data_i,
   input  logic [1:0]           dmi_resp_resp_i
);

   localparam int unsigned DmiWidth = AddrWidth + 34;

   // Handshakes: a request is transferred on a cycle where dmi_req_valid_o and
   // dmi_req_ready_i are both high; valid and its payload stay stable until then.
   // A response is consumed on a cycle where dmi_resp_valid_i and dmi_resp_ready_o are high.
   typedef enum logic [2:0] {
      Idle,
      Read,
      WaitRead,
      Write,
      WaitWrite
   } state_e;

   state_e                state_q, state_d;
   logic [31:0]           dtmcs_q;
   logic [DmiWidth-1:0]   dmi_q;
   logic [AddrWidth-1:0]  addr_q;
   logic [31:0]           data_q;
   logic [1:0]            error_q;
   logic                  dmi_rst_q;

   logic dtmcs_capture, dtmcs_shift, dtmcs_update;
   logic dmi_capture, dmi_shift, dmi_update;
   logic hard_reset, err_clear, busy, dmi_start;
   logic [1:0]           scan_op;
   logic [31:0]          scan_data;
   logic [AddrWidth-1:0] scan_addr;

   assign dtmcs_capture = capture_i & dtmcs_select_i;
   assign dtmcs_shift   = shift_i   & dtmcs_select_i;
   assign dtmcs_update  = update_i  & dtmcs_select_i;
   assign dmi_capture   = capture_i & dmi_select_i;
   assign dmi_shift     = shift_i   & dmi_select_i;
   assign dmi_update    = update_i  & dmi_select_i;

   assign scan_op   = dmi_q[1:0];
   assign scan_data = dmi_q[33:2];
   assign scan_addr = dmi_q[DmiWidth-1:34];

   // TAP Test-Logic-Reset behaves exactly like dmihardreset.
   assign hard_reset = dmi_clear_i | (dtmcs_update & dtmcs_q[17]);
   assign err_clear  = hard_reset | (dtmcs_update & dtmcs_q[16]);
   assign busy       = (state_q != Idle);
   assign dmi_start  = dmi_update & ~busy & (error_q == 2'd0);

   assign dtmcs_tdo_o    = dtmcs_q[0];
   assign dmi_tdo_o      = dmi_q[0];
   assign dmi_rst_no     = dmi_rst_q;
   assign dmi_req_addr_o = addr_q;
   assign dmi_req_data_o = data_q;

   always_comb begin
      state_d          = state_q;
      dmi_req_valid_o  = 1'b0;
      dmi_req_op_o     = 2'd0;
      dmi_resp_ready_o = 1'b0;
      unique case (state_q)
         Idle: begin
            if (dmi_start && scan_op == 2'd1) state_d = Read;
            if (dmi_start && scan_op == 2'd2) state_d = Write;
         end
         Read: begin
            dmi_req_valid_o = 1'b1;
            dmi_req_op_o    = 2'd1;
            if (dmi_req_ready_i) state_d = WaitRead;
         end
         Write: begin
            dmi_req_valid_o = 1'b1;
            dmi_req_op_o    = 2'd2;
            if (dmi_req_ready_i) state_d = WaitWrite;
         end
         WaitRead, WaitWrite: begin
            dmi_resp_ready_o = 1'b1;
            if (dmi_resp_valid_i) state_d = Idle;
         end
         default: state_d = Idle;
      endcase
      if (hard_reset) state_d = Idle;
   end

   always_ff @(posedge tck_i or negedge trst_ni) begin
      if (!trst_ni) begin
         state_q   <= Idle;
         dtmcs_q   <= '0;
         dmi_q     <= '0;
         addr_q    <= '0;
         data_q    <= '0;
         error_q   <= 2'd0;
         dmi_rst_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         dmi_rst_q <= ~hard_reset;

         if (dtmcs_capture)
            dtmcs_q <= {14'b0, 1'b0, 1'b0, 1'b0, 3'(IdleCycles), error_q, 6'(AddrWidth), 4'd1};
         else if (dtmcs_shift)
            dtmcs_q <= {tdi_i, dtmcs_q[31:1]};

         // A capture during an outstanding access reports busy in the op field.
         if (dmi_capture)
            dmi_q <= {addr_q, data_q, (busy ? 2'd3 : error_q)};
         else if (dmi_shift)
            dmi_q <= {tdi_i, dmi_q[DmiWidth-1:1]};

         // Sticky: the first error recorded is kept until an explicit clear.
         if (err_clear)
            error_q <= 2'd0;
         else if (error_q == 2'd0) begin
            if ((dmi_capture || dmi_update) && busy)
               error_q <= 2'd3;
            else if (dmi_resp_ready_o && dmi_resp_valid_i && dmi_resp_resp_i != 2'd0)
               error_q <= dmi_resp_resp_i;
         end

         if (dmi_start && (scan_op == 2'd1 || scan_op == 2'd2))
            addr_q <= scan_addr;
         if (dmi_start && scan_op == 2'd2)
            data_q <= scan_data;
         else if (state_q == WaitRead && dmi_resp_valid_i && !hard_reset)
            data_q <= dmi_resp_data_i;
      end
   end

endmodule

// File: tb/tb_dmi_jtag_dr.sv
// Directed bench for dmi_jtag_dr: drives DR scans like the TAP would and checks
// TDO streams, request/response handshakes, sticky errors and reset pulses.
module tb_dmi_jtag_dr;

   logic        tck_i = 1'b0;
   logic        trst_ni;
   logic        dmi_clear_i, capture_i, shift_i, update_i, tdi_i;
   logic        dtmcs_select_i, dmi_select_i;
   logic        dtmcs_tdo_o, dmi_tdo_o, dmi_rst_no;
   logic        dmi_req_valid_o, dmi_req_ready_i;
   logic [6:0]  dmi_req_addr_o;
   logic [1:0]  dmi_req_op_o;
   logic [31:0] dmi_req_data_o;
   logic        dmi_resp_valid_i, dmi_resp_ready_o;
   logic [31:0] dmi_resp_data_i;
   logic [1:0]  dmi_resp_resp_i;

   int n_cmp = 0;
   int n_mis = 0;
   logic [40:0] sout;

   // clock / reset
   always #5 tck_i = ~tck_i;

   dmi_jtag_dr #(.AddrWidth(7), .IdleCycles(1)) dut (
      .tck_i            (tck_i),
      .trst_ni          (trst_ni),
      .dmi_clear_i      (dmi_clear_i),
      .capture_i        (capture_i),
      .shift_i          (shift_i),
      .update_i         (update_i),
      .tdi_i            (tdi_i),
      .dtmcs_select_i   (dtmcs_select_i),
      .dtmcs_tdo_o      (dtmcs_tdo_o),
      .dmi_select_i     (dmi_select_i),
      .dmi_tdo_o        (dmi_tdo_o),
      .dmi_rst_no       (dmi_rst_no),
      .dmi_req_valid_o  (dmi_req_valid_o),
      .dmi_req_ready_i  (dmi_req_ready_i),
      .dmi_req_addr_o   (dmi_req_addr_o),
      .dmi_req_op_o     (dmi_req_op_o),
      .dmi_req_data_o   (dmi_req_data_o),
      .dmi_resp_valid_i (dmi_resp_valid_i),
      .dmi_resp_ready_o (dmi_resp_ready_o),
      .dmi_resp_data_i  (dmi_resp_data_i),
      .dmi_resp_resp_i  (dmi_resp_resp_i)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge tck_i);
   endtask

   function automatic logic [40:0] dmi_vec(input logic [6:0] a, input logic [31:0] d,
                                           input logic [1:0] op);
      return {a, d, op};
   endfunction

   // Capture, shift LSB-first while recording TDO, then update. Called at a negedge.
   task automatic dr_scan(input bit is_dtmcs, input logic [40:0] din, output logic [40:0] dout);
      int w;
      w = is_dtmcs ? 32 : 41;
      dout = '0;
      dtmcs_select_i = is_dtmcs;
      dmi_select_i   = !is_dtmcs;
      capture_i      = 1'b1;
      tick();
      capture_i = 1'b0;
      shift_i   = 1'b1;
      for (int i = 0; i < w; i++) begin
         dout[i] = is_dtmcs ? dtmcs_tdo_o : dmi_tdo_o;
         tdi_i   = din[i];
         tick();
      end
      shift_i  = 1'b0;
      update_i = 1'b1;
      tick();
      update_i       = 1'b0;
      dtmcs_select_i = 1'b0;
      dmi_select_i   = 1'b0;
   endtask

   initial begin
      trst_ni = 1'b0; dmi_clear_i = 1'b0; capture_i = 1'b0; shift_i = 1'b0;
      update_i = 1'b0; tdi_i = 1'b0; dtmcs_select_i = 1'b0; dmi_select_i = 1'b0;
      dmi_req_ready_i = 1'b0; dmi_resp_valid_i = 1'b0; dmi_resp_data_i = '0;
      dmi_resp_resp_i = 2'd0;
      repeat (2) tick();

      // reset state
      chk("rst_dmi_rst_no", dmi_rst_no, 1);
      chk("rst_req_valid", dmi_req_valid_o, 0);
      chk("rst_resp_ready", dmi_resp_ready_o, 0);
      chk("rst_req_op", dmi_req_op_o, 0);
      chk("rst_req_addr", dmi_req_addr_o, 0);
      chk("rst_req_data", dmi_req_data_o, 0);
      chk("rst_tdo", {dtmcs_tdo_o, dmi_tdo_o}, 0);
      trst_ni = 1'b1;
      tick();

      // DTMCS id stream
      dr_scan(1, '0, sout);
      chk("dtmcs_capture", sout[31:0], 32'h0000_1071);

      // write 0x10 <- 0x80000001, accepted immediately
      dmi_req_ready_i = 1'b1;
      dr_scan(0, dmi_vec(7'h10, 32'h8000_0001, 2'd2), sout);
      chk("wr_valid", dmi_req_valid_o, 1);
      chk("wr_addr", dmi_req_addr_o, 7'h10);
      chk("wr_op", dmi_req_op_o, 2);
      chk("wr_data", dmi_req_data_o, 32'h8000_0001);
      tick();
      dmi_req_ready_i = 1'b0;
      chk("wr_valid_one_cycle", dmi_req_valid_o, 0);
      chk("wr_resp_ready", dmi_resp_ready_o, 1);
      dmi_resp_valid_i = 1'b1; dmi_resp_data_i = 32'h1234_5678; dmi_resp_resp_i = 2'd0;
      tick();
      dmi_resp_valid_i = 1'b0;
      chk("wr_done_resp_ready", dmi_resp_ready_o, 0);

      // read 0x11 with a stalled request
      dr_scan(0, dmi_vec(7'h11, 32'h0, 2'd1), sout);
      chk("rd_capture_prev_write", sout, dmi_vec(7'h10, 32'h8000_0001, 2'd0));
      for (int i = 0; i < 5; i++) begin
         chk("rd_stall_req", {dmi_req_valid_o, dmi_req_op_o, dmi_req_addr_o}, {1'b1, 2'd1, 7'h11});
         tick();
      end
      dmi_req_ready_i = 1'b1;
      tick();
      dmi_req_ready_i = 1'b0;
      chk("rd_accepted_valid", dmi_req_valid_o, 0);
      repeat (2) begin
         chk("rd_wait_resp_ready", dmi_resp_ready_o, 1);
         tick();
      end
      dmi_resp_valid_i = 1'b1; dmi_resp_data_i = 32'hDEAD_BEEF; dmi_resp_resp_i = 2'd0;
      tick();
      dmi_resp_valid_i = 1'b0;
      dr_scan(0, '0, sout);
      chk("rd_capture_data", sout, dmi_vec(7'h11, 32'hDEAD_BEEF, 2'd0));
      chk("nop_no_request", dmi_req_valid_o, 0);

      // capture while WaitRead -> busy, then requests blocked until dmireset
      dmi_req_ready_i = 1'b1;
      dr_scan(0, dmi_vec(7'h05, 32'h0, 2'd1), sout);
      tick();
      dmi_req_ready_i = 1'b0;
      dr_scan(0, dmi_vec(7'h22, 32'hCAFE_F00D, 2'd2), sout);
      chk("busy_capture", sout, dmi_vec(7'h05, 32'hDEAD_BEEF, 2'd3));
      chk("busy_no_request", dmi_req_valid_o, 0);
      chk("busy_still_waiting", dmi_resp_ready_o, 1);
      dmi_resp_valid_i = 1'b1; dmi_resp_data_i = 32'h1111_1111; dmi_resp_resp_i = 2'd0;
      tick();
      dmi_resp_valid_i = 1'b0;
      dr_scan(1, '0, sout);
      chk("busy_dmistat", sout[31:0], 32'h0000_1C71);
      dmi_req_ready_i = 1'b1;
      dr_scan(0, dmi_vec(7'h22, 32'hCAFE_F00D, 2'd2), sout);
      chk("err_capture_op", sout, dmi_vec(7'h05, 32'h1111_1111, 2'd3));
      chk("err_blocks_request", dmi_req_valid_o, 0);
      dr_scan(1, 41'h1_0000, sout);
      dr_scan(1, '0, sout);
      chk("dmireset_clears", sout[31:0], 32'h0000_1071);
      dr_scan(0, dmi_vec(7'h22, 32'hCAFE_F00D, 2'd2), sout);
      chk("resume_req", {dmi_req_valid_o, dmi_req_op_o, dmi_req_addr_o}, {1'b1, 2'd2, 7'h22});
      chk("resume_data", dmi_req_data_o, 32'hCAFE_F00D);
      tick();
      dmi_resp_valid_i = 1'b1; dmi_resp_resp_i = 2'd0;
      tick();
      dmi_resp_valid_i = 1'b0;

      // failed read sets error 2, which then sticks
      dr_scan(0, dmi_vec(7'h01, 32'h0, 2'd1), sout);
      tick();
      dmi_req_ready_i = 1'b0;
      dmi_resp_valid_i = 1'b1; dmi_resp_data_i = 32'hAAAA_5555; dmi_resp_resp_i = 2'd2;
      tick();
      dmi_resp_valid_i = 1'b0; dmi_resp_resp_i = 2'd0;
      dr_scan(1, '0, sout);
      chk("failed_dmistat", sout[31:0], 32'h0000_1871);
      dr_scan(0, dmi_vec(7'h33, 32'h1234_5678, 2'd2), sout);
      chk("failed_capture", sout, dmi_vec(7'h01, 32'hAAAA_5555, 2'd2));
      chk("failed_no_request", dmi_req_valid_o, 0);
      dr_scan(1, '0, sout);
      chk("failed_sticky", sout[31:0], 32'h0000_1871);
      dr_scan(1, 41'h1_0000, sout);

      // dmihardreset during WaitWrite
      dmi_req_ready_i = 1'b1;
      dr_scan(0, dmi_vec(7'h44, 32'h0F0F_0F0F, 2'd2), sout);
      tick();
      dmi_req_ready_i = 1'b0;
      chk("hr_in_wait", dmi_resp_ready_o, 1);
      dr_scan(1, 41'h2_0000, sout);
      chk("hr_prev_dtmcs", sout[31:0], 32'h0000_1071);
      chk("hr_rst_low", dmi_rst_no, 0);
      chk("hr_resp_ready_drop", {dmi_resp_ready_o, dmi_req_valid_o}, 0);
      tick();
      chk("hr_rst_one_cycle", dmi_rst_no, 1);
      chk("hr_idle", dmi_resp_ready_o, 0);

      // dmi_clear_i during WaitWrite
      dmi_req_ready_i = 1'b1;
      dr_scan(0, dmi_vec(7'h45, 32'h5A5A_A5A5, 2'd2), sout);
      tick();
      dmi_req_ready_i = 1'b0;
      chk("clr_in_wait", dmi_resp_ready_o, 1);
      dmi_clear_i = 1'b1;
      tick();
      dmi_clear_i = 1'b0;
      chk("clr_rst_low", dmi_rst_no, 0);
      chk("clr_resp_ready_drop", dmi_resp_ready_o, 0);
      tick();
      chk("clr_rst_one_cycle", dmi_rst_no, 1);
      dr_scan(0, '0, sout);
      chk("clr_capture", sout, dmi_vec(7'h45, 32'h5A5A_A5A5, 2'd0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
